// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU-control decode stage: ALU codes,
// PSR write-enable classes, opcode field values, FSM state and decode record.
package alu_pkg;

   localparam logic [4:0] ALU_ADD   = 5'b00000;
   localparam logic [4:0] ALU_SUB   = 5'b00001;
   localparam logic [4:0] ALU_MUL   = 5'b00010;
   localparam logic [4:0] ALU_AND   = 5'b00011;
   localparam logic [4:0] ALU_OR    = 5'b00100;
   localparam logic [4:0] ALU_XOR   = 5'b00101;
   localparam logic [4:0] ALU_SCOND = 5'b00111;
   localparam logic [4:0] ALU_MOV   = 5'b01000;
   localparam logic [4:0] ALU_LUI   = 5'b01001;
   localparam logic [4:0] ALU_NOT   = 5'b01010;
   localparam logic [4:0] ALU_LSH   = 5'b01011;
   localparam logic [4:0] ALU_SHL   = 5'b01100;
   localparam logic [4:0] ALU_LSHR  = 5'b01101;
   localparam logic [4:0] ALU_ASHU  = 5'b01110;
   localparam logic [4:0] ALU_ASHR  = 5'b01111;
   localparam logic [4:0] ALU_BCOND = 5'b10000;
   localparam logic [4:0] ALU_JCOND = 5'b10001;

   // PSR enables are ordered {C,L,F,Z,N}
   localparam logic [4:0] PSR_ARITH = 5'b10111;
   localparam logic [4:0] PSR_CMP   = 5'b01011;
   localparam logic [4:0] PSR_LOGIC = 5'b00010;
   localparam logic [4:0] PSR_NONE  = 5'b00000;

   localparam logic [3:0] OP_REG   = 4'h0;
   localparam logic [3:0] OP_SPEC  = 4'h4;
   localparam logic [3:0] OP_SHIFT = 4'h8;
   localparam logic [3:0] OP_BCOND = 4'hC;
   localparam logic [3:0] OP_MULI  = 4'hE;
   localparam logic [3:0] FN_MUL   = 4'hE;

   typedef enum logic [1:0] {IDLE, FULL, MULBUSY} stateT;

   typedef struct packed {
      logic [4:0] aluCtrl;
      logic [4:0] psrWrEn;
      logic       illegal;
      logic       isMul;
   } decodeT;

endpackage

// File: rtl/alu_ctrl_stage_if.sv
// Handshake bus of the ALU-control stage: instruction side in, ALU/PSR side out.
interface alu_ctrl_stage_if;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] oper;
   logic [3:0] func;
   logic [3:0] cond;
   logic       flush;
   logic       out_ready;
   logic       out_valid;
   logic [4:0] alu_ctrl;
   logic [4:0] psr_wr_en;
   logic [3:0] cond_out;
   logic       illegal;

   modport master (
      output in_valid, oper, func, cond, flush, out_ready,
      input  in_ready, out_valid, alu_ctrl, psr_wr_en, cond_out, illegal
   );

   modport slave (
      input  in_valid, oper, func, cond, flush, out_ready,
      output in_ready, out_valid, alu_ctrl, psr_wr_en, cond_out, illegal
   );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Pure combinational decode of oper/func into ALU code, PSR enables,
// illegal flag and multiply marker. Illegal encodings leave code and enables at zero.
module alu_ctrl_decode
   import alu_pkg::*;
(
   input  logic [3:0] oper,
   input  logic [3:0] func,
   output decodeT     dec
);

   always_comb begin
      dec = '0;
      case (oper)
         OP_REG: begin
            case (func)
               4'h1: begin dec.aluCtrl = ALU_AND; dec.psrWrEn = PSR_LOGIC; end
               4'h2: begin dec.aluCtrl = ALU_OR;  dec.psrWrEn = PSR_LOGIC; end
               4'h3: begin dec.aluCtrl = ALU_XOR; dec.psrWrEn = PSR_LOGIC; end
               4'h4: begin dec.aluCtrl = ALU_NOT; dec.psrWrEn = PSR_LOGIC; end
               4'h5, 4'h6: begin dec.aluCtrl = ALU_ADD; dec.psrWrEn = PSR_ARITH; end
               4'h7: dec.aluCtrl = ALU_ADD;
               4'h9, 4'hA: begin dec.aluCtrl = ALU_SUB; dec.psrWrEn = PSR_ARITH; end
               4'hB: begin dec.aluCtrl = ALU_SUB; dec.psrWrEn = PSR_CMP; end
               4'hD: dec.aluCtrl = ALU_MOV;
               FN_MUL: begin dec.aluCtrl = ALU_MUL; dec.isMul = 1'b1; end
               4'hF: begin dec.aluCtrl = ALU_AND; dec.psrWrEn = PSR_LOGIC; end
               default: dec.illegal = 1'b1;
            endcase
         end
         OP_SPEC: begin
            case (func)
               4'h8: dec.aluCtrl = ALU_MOV;
               4'hC: dec.aluCtrl = ALU_JCOND;
               4'hD: dec.aluCtrl = ALU_SCOND;
               default: dec.illegal = 1'b1;
            endcase
         end
         OP_SHIFT: begin
            case (func)
               4'h0, 4'h2: dec.aluCtrl = ALU_SHL;
               4'h1: dec.aluCtrl = ALU_LSHR;
               4'h3: dec.aluCtrl = ALU_ASHR;
               4'h4: dec.aluCtrl = ALU_LSH;
               4'h6: dec.aluCtrl = ALU_ASHU;
               default: dec.illegal = 1'b1;
            endcase
         end
         OP_BCOND: dec.aluCtrl = ALU_BCOND;
         default: begin
            // remaining opers are the immediate forms, decoded by oper alone
            case (oper)
               4'h1: begin dec.aluCtrl = ALU_AND; dec.psrWrEn = PSR_LOGIC; end
               4'h2: begin dec.aluCtrl = ALU_OR;  dec.psrWrEn = PSR_LOGIC; end
               4'h3: begin dec.aluCtrl = ALU_XOR; dec.psrWrEn = PSR_LOGIC; end
               4'h5, 4'h6: begin dec.aluCtrl = ALU_ADD; dec.psrWrEn = PSR_ARITH; end
               4'h7: dec.aluCtrl = ALU_ADD;
               4'h9, 4'hA: begin dec.aluCtrl = ALU_SUB; dec.psrWrEn = PSR_ARITH; end
               4'hB: begin dec.aluCtrl = ALU_SUB; dec.psrWrEn = PSR_CMP; end
               4'hD: dec.aluCtrl = ALU_MOV;
               OP_MULI: begin dec.aluCtrl = ALU_MUL; dec.isMul = 1'b1; end
               4'hF: dec.aluCtrl = ALU_LUI;
               default: dec.illegal = 1'b1;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/alu_ctrl_stage.sv
// Registered, handshaked ALU-control stage: decodes one instruction per
// transfer and holds multiplies for MUL_CYCLES before presenting them.
module alu_ctrl_stage
   import alu_pkg::*;
#(
   parameter int MUL_CYCLES = 3,
   parameter int CNT_W      = 2
) (
   input  logic            clk,
   input  logic            reset,
   alu_ctrl_stage_if.slave bus
);

   stateT             state, stateNext;
   logic [CNT_W-1:0]  count, countNext;
   decodeT            dec;
   logic              accept, load;
   logic [4:0]        aluQ, psrQ;
   logic [3:0]        condQ;
   logic              illQ;

   alu_ctrl_decode uDec (
      .oper (bus.oper),
      .func (bus.func),
      .dec  (dec)
   );

   assign bus.in_ready = (state == IDLE) | ((state == FULL) & bus.out_ready);
   assign accept       = bus.in_valid & bus.in_ready;

   always_comb begin
      stateNext = state;
      countNext = count;
      load      = 1'b0;
      if (bus.flush) begin
         // flush wins over a same-cycle accept; that input is dropped
         stateNext = IDLE;
         countNext = '0;
      end else if (accept) begin
         load = 1'b1;
         if (dec.isMul && (MUL_CYCLES > 1)) begin
            stateNext = MULBUSY;
            countNext = CNT_W'(MUL_CYCLES - 1);
         end else begin
            stateNext = FULL;
         end
      end else begin
         case (state)
            MULBUSY: begin
               if (count == '0) stateNext = FULL;
               else             countNext = count - CNT_W'(1);
            end
            FULL:    if (bus.out_ready) stateNext = IDLE;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         count <= '0;
         aluQ  <= '0;
         psrQ  <= '0;
         condQ <= '0;
         illQ  <= 1'b0;
      end else begin
         state <= stateNext;
         count <= countNext;
         if (load) begin
            aluQ  <= dec.aluCtrl;
            psrQ  <= dec.psrWrEn;
            condQ <= bus.cond;
            illQ  <= dec.illegal;
         end
      end
   end

   assign bus.out_valid = (state == FULL);
   assign bus.alu_ctrl  = aluQ;
   assign bus.psr_wr_en = psrQ;
   assign bus.cond_out  = condQ;
   assign bus.illegal   = illQ;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Bench for alu_ctrl_stage: table-driven reference decode plus a transfer-level
// occupancy model, directed scenarios with literal expectations, then random traffic.
module tb_alu_ctrl_stage;

   localparam int MC = 3;
   localparam int A  = 23;  // 10111
   localparam int C  = 11;  // 01011
   localparam int L  = 2;   // 00010
   localparam int N  = 0;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   alu_ctrl_stage_if bus();

   alu_ctrl_stage #(.MUL_CYCLES(MC), .CNT_W(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int nChecks = 0;
   int nErrors = 0;

   // model: is a result presented, cycles left before a multiply is shown, and its content
   bit mValid;
   int mBusy;
   int mAlu, mPsr, mCond, mIll;

   // -1 marks an undefined encoding
   int aluR [16] = '{-1, 3, 4, 5, 10, 0, 0, 0, -1, 1, 1, 1, -1, 8, 2, 3};
   int psrR [16] = '{ 0, L, L, L,  L, A, A, N,  0, A, A, C,  0, N, N, L};
   int aluI [16] = '{-1, 3, 4, 5, -1, 0, 0, 0, -1, 1, 1, 1, -1, 8, 2, 9};
   int psrI [16] = '{ 0, L, L, L,  0, A, A, N,  0, A, A, C,  0, N, N, N};
   int aluSh[16] = '{12, 13, 12, 15, 11, -1, 14, -1, -1, -1, -1, -1, -1, -1, -1, -1};

   function automatic void refDecode(input int op, input int fn,
                                     output int alu, output int psr,
                                     output int ill, output int mul);
      alu = -1; psr = 0; mul = 0;
      case (op)
         0:  begin alu = aluR[fn]; psr = psrR[fn]; mul = int'(fn == 14); end
         4:  alu = (fn == 8) ? 8 : (fn == 12) ? 17 : (fn == 13) ? 7 : -1;
         8:  alu = aluSh[fn];
         12: alu = 16;
         default: begin alu = aluI[op]; psr = psrI[op]; mul = int'(op == 14); end
      endcase
      ill = int'(alu < 0);
      if (alu < 0) begin alu = 0; psr = 0; mul = 0; end
   endfunction

   task automatic chk(input string nm, input int got, input int exp);
      nChecks++;
      if (got != exp) begin
         nErrors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
      end
   endtask

   task automatic checkOut();
      chk("out_valid", int'(bus.out_valid), int'(mValid));
      if (mValid) begin
         chk("alu_ctrl",  int'(bus.alu_ctrl),  mAlu);
         chk("psr_wr_en", int'(bus.psr_wr_en), mPsr);
         chk("cond_out",  int'(bus.cond_out),  mCond);
         chk("illegal",   int'(bus.illegal),   mIll);
      end
   endtask

   // one clock: drive inputs, check in_ready, advance model, check outputs after the edge
   task automatic step(input bit iv, input int op, input int fn, input int cd,
                       input bit fl, input bit ordy);
      int alu, psr, ill, mul;
      bit rdy;
      @(negedge clk);
      bus.in_valid  = iv;
      bus.oper      = 4'(op);
      bus.func      = 4'(fn);
      bus.cond      = 4'(cd);
      bus.flush     = fl;
      bus.out_ready = ordy;
      rdy = (mBusy == 0) && (!mValid || ordy);
      #1 chk("in_ready", int'(bus.in_ready), int'(rdy));
      if (fl) begin
         mValid = 1'b0; mBusy = 0;
      end else if (iv && rdy) begin
         refDecode(op, fn, alu, psr, ill, mul);
         mAlu = alu; mPsr = psr; mIll = ill; mCond = cd;
         if (mul != 0 && MC > 1) begin mBusy = MC; mValid = 1'b0; end
         else mValid = 1'b1;
      end else if (mBusy > 0) begin
         mBusy--;
         if (mBusy == 0) mValid = 1'b1;
      end else if (mValid && ordy) begin
         mValid = 1'b0;
      end
      @(posedge clk);
      #1 checkOut();
   endtask

   task automatic doReset();
      @(negedge clk);
      reset = 1'b1;
      bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
      bus.oper = '0; bus.func = '0; bus.cond = '0;
      @(posedge clk);
      #1;
      mValid = 1'b0; mBusy = 0;
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_alu_ctrl",  int'(bus.alu_ctrl),  0);
      chk("rst_psr",       int'(bus.psr_wr_en), 0);
      chk("rst_cond_out",  int'(bus.cond_out),  0);
      chk("rst_illegal",   int'(bus.illegal),   0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      doReset();

      // add -> 1-cycle latency
      step(1, 0, 5, 0, 0, 1);
      chk("t1_valid", int'(bus.out_valid), 1);
      chk("t1_alu", int'(bus.alu_ctrl), 0);
      chk("t1_psr", int'(bus.psr_wr_en), 23);
      step(0, 0, 0, 0, 0, 1);

      // muli: three busy cycles with in_ready low, then presented
      step(1, 14, 0, 0, 0, 1);
      chk("t2_busy0", int'(bus.out_valid), 0);
      step(0, 0, 0, 0, 0, 1);
      chk("t2_busy1", int'(bus.out_valid), 0);
      step(0, 0, 0, 0, 0, 1);
      chk("t2_busy2", int'(bus.out_valid), 0);
      step(0, 0, 0, 0, 0, 1);
      chk("t2_valid", int'(bus.out_valid), 1);
      chk("t2_alu", int'(bus.alu_ctrl), 2);
      chk("t2_psr", int'(bus.psr_wr_en), 0);
      step(0, 0, 0, 0, 0, 1);

      // test, then cmpi back-to-back
      step(1, 0, 15, 0, 0, 1);
      chk("t3_test_alu", int'(bus.alu_ctrl), 3);
      chk("t3_test_psr", int'(bus.psr_wr_en), 2);
      step(1, 11, 0, 0, 0, 1);
      chk("t3_cmpi_valid", int'(bus.out_valid), 1);
      chk("t3_cmpi_alu", int'(bus.alu_ctrl), 1);
      chk("t3_cmpi_psr", int'(bus.psr_wr_en), 11);

      // stall four cycles with an op waiting, then release straight into it
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 1, 0, 0, 0);
         chk("t4_hold_alu", int'(bus.alu_ctrl), 1);
         chk("t4_hold_ready", int'(bus.in_ready), 0);
      end
      step(1, 0, 1, 0, 0, 1);
      chk("t4_b2b_valid", int'(bus.out_valid), 1);
      chk("t4_b2b_alu", int'(bus.alu_ctrl), 3);
      step(0, 0, 0, 0, 0, 1);

      // flush in the second cycle of a multiply, then addu
      step(1, 0, 14, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1, 1);
      chk("t5_flush_valid", int'(bus.out_valid), 0);
      step(0, 0, 0, 0, 0, 1);
      chk("t5_idle_valid", int'(bus.out_valid), 0);
      step(1, 0, 7, 0, 0, 1);
      chk("t5_addu_valid", int'(bus.out_valid), 1);
      chk("t5_addu_alu", int'(bus.alu_ctrl), 0);
      chk("t5_addu_psr", int'(bus.psr_wr_en), 0);
      step(1, 0, 5, 0, 1, 1);
      chk("t5_flush_drop", int'(bus.out_valid), 0);

      // illegal op still transfers; bcond passes cond through
      step(1, 4, 0, 0, 0, 1);
      chk("t6_ill_valid", int'(bus.out_valid), 1);
      chk("t6_ill_flag", int'(bus.illegal), 1);
      chk("t6_ill_alu", int'(bus.alu_ctrl), 0);
      chk("t6_ill_psr", int'(bus.psr_wr_en), 0);
      step(1, 12, 3, 5, 0, 1);
      chk("t6_bcond_alu", int'(bus.alu_ctrl), 16);
      chk("t6_bcond_cond", int'(bus.cond_out), 5);
      chk("t6_bcond_ill", int'(bus.illegal), 0);
      step(0, 0, 0, 0, 0, 1);

      // reset in the middle of a multiply
      step(1, 0, 14, 9, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      doReset();
      step(0, 0, 0, 0, 0, 1);
      chk("t7_after_rst", int'(bus.out_valid), 0);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) doReset();
         step($urandom_range(0, 9) < 7, int'($urandom_range(0, 15)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              $urandom_range(0, 24) == 0, $urandom_range(0, 9) < 7);
      end

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
